// File: rtl/cpu_pkg.sv
// Shared decode constants for the control sequencer.
//   - opcode match patterns for the supported instruction subset
//   - ALU operation codes driven on alu_cntrl
//   - condition code recognised for conditional branches (LT only)
//   - sequencer state enum and flag-vector bit positions
package cpu_pkg;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  localparam logic [9:0]  OP_ADDI  = 10'b1001000100;
  localparam logic [10:0] OP_ADDS  = 11'b10101011000;
  localparam logic [10:0] OP_SUBS  = 11'b11101011000;
  localparam logic [10:0] OP_LDUR  = 11'b11111000010;
  localparam logic [10:0] OP_STUR  = 11'b11111000000;
  localparam logic [5:0]  OP_B     = 6'b000101;
  localparam logic [7:0]  OP_CBZ   = 8'b10110100;
  localparam logic [7:0]  OP_BCOND = 8'b01010100;
  localparam logic [4:0]  COND_LT  = 5'b01011;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  localparam logic [3:0] XFER_DWORD = 4'd8;

  // flags vector layout is {N,Z,V,C}
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  // signed less-than: N differs from V
  function automatic logic lt_taken(input logic [3:0] f);
    return f[FLAG_N] ^ f[FLAG_V];
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Bus between the control sequencer and the datapath.
//   master : sequencer side (receives instruction + ALU flags, drives PC,
//            register specifiers, immediate, controls and status)
//   slave  : datapath side (mirror image of master)
interface control_sequencer_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic [31:0]       instruction;
  logic              alu_zero;
  logic              alu_negative;
  logic              alu_overflow;
  logic              alu_carry;
  logic [ADDR_W-1:0] PC;
  logic [4:0]        Rd;
  logic [4:0]        Rn;
  logic [4:0]        Rm;
  logic [DATA_W-1:0] imm;
  logic              Reg2Loc;
  logic              RegWrite;
  logic              MemWrite;
  logic              MemToReg;
  logic              ALUSrc;
  logic [2:0]        alu_cntrl;
  logic [3:0]        xfer_size;
  logic [3:0]        flags;
  logic              halted;
  logic              illegal;

  modport master (
    input  instruction, alu_zero, alu_negative, alu_overflow, alu_carry,
    output PC, Rd, Rn, Rm, imm, Reg2Loc, RegWrite, MemWrite, MemToReg, ALUSrc,
           alu_cntrl, xfer_size, flags, halted, illegal
  );

  modport slave (
    output instruction, alu_zero, alu_negative, alu_overflow, alu_carry,
    input  PC, Rd, Rn, Rm, imm, Reg2Loc, RegWrite, MemWrite, MemToReg, ALUSrc,
           alu_cntrl, xfer_size, flags, halted, illegal
  );
endinterface

// File: rtl/instr_decode.sv
// Purely combinational instruction decoder.
//   instruction : 32-bit instruction word
//   rd/rn/rm    : register specifier fields
//   imm         : extended immediate for the datapath
//   reg2loc .. xfer_size : datapath controls (ungated by sequencer state)
//   flag_we     : instruction writes the NZVC flags
//   br_uncond/br_cbz/br_lt : branch class of the instruction
//   br_off      : sign-extended branch offset already scaled to bytes
//   halt_req    : B with a zero offset (branch-to-self terminates)
//   illegal     : opcode not recognised
module instr_decode
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic [31:0]              instruction,
  output logic [4:0]               rd,
  output logic [4:0]               rn,
  output logic [4:0]               rm,
  output logic [DATA_W-1:0]        imm,
  output logic                     reg2loc,
  output logic                     reg_write,
  output logic                     mem_write,
  output logic                     mem_to_reg,
  output logic                     alu_src,
  output logic [2:0]               alu_cntrl,
  output logic [3:0]               xfer_size,
  output logic                     flag_we,
  output logic                     br_uncond,
  output logic                     br_cbz,
  output logic                     br_lt,
  output logic                     halt_req,
  output logic                     illegal,
  output logic signed [ADDR_W-1:0] br_off
);

  // Extensions are built wider than needed and truncated, so any
  // ADDR_W/DATA_W works including widths narrower than the field.
  logic [DATA_W+11:0] imm12_z;
  logic [DATA_W+8:0]  imm9_s;
  logic [DATA_W+25:0] imm26_s;
  logic [DATA_W+18:0] imm19_s;
  logic [ADDR_W+27:0] off26;
  logic [ADDR_W+20:0] off19;

  assign imm12_z = {{DATA_W{1'b0}}, instruction[21:10]};
  assign imm9_s  = {{DATA_W{instruction[20]}}, instruction[20:12]};
  assign imm26_s = {{DATA_W{instruction[25]}}, instruction[25:0]};
  assign imm19_s = {{DATA_W{instruction[23]}}, instruction[23:5]};
  assign off26   = {{ADDR_W{instruction[25]}}, instruction[25:0], 2'b00};
  assign off19   = {{ADDR_W{instruction[23]}}, instruction[23:5], 2'b00};

  assign rd = instruction[4:0];
  assign rn = instruction[9:5];
  assign rm = instruction[20:16];

  always_comb begin
    imm        = '0;
    reg2loc    = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_cntrl  = ALU_PASS_B;
    xfer_size  = 4'd0;
    flag_we    = 1'b0;
    br_uncond  = 1'b0;
    br_cbz     = 1'b0;
    br_lt      = 1'b0;
    halt_req   = 1'b0;
    illegal    = 1'b0;
    br_off     = '0;
    if (instruction[31:22] == OP_ADDI) begin
      imm       = imm12_z[DATA_W-1:0];
      alu_src   = 1'b1;
      alu_cntrl = ALU_ADD;
      reg_write = 1'b1;
    end else if (instruction[31:21] == OP_ADDS) begin
      reg2loc   = 1'b1;
      alu_cntrl = ALU_ADD;
      reg_write = 1'b1;
      flag_we   = 1'b1;
    end else if (instruction[31:21] == OP_SUBS) begin
      reg2loc   = 1'b1;
      alu_cntrl = ALU_SUB;
      reg_write = 1'b1;
      flag_we   = 1'b1;
    end else if (instruction[31:21] == OP_LDUR) begin
      imm        = imm9_s[DATA_W-1:0];
      alu_src    = 1'b1;
      alu_cntrl  = ALU_ADD;
      mem_to_reg = 1'b1;
      reg_write  = 1'b1;
      xfer_size  = XFER_DWORD;
    end else if (instruction[31:21] == OP_STUR) begin
      imm       = imm9_s[DATA_W-1:0];
      alu_src   = 1'b1;
      alu_cntrl = ALU_ADD;
      mem_write = 1'b1;
      xfer_size = XFER_DWORD;
    end else if (instruction[31:26] == OP_B) begin
      imm       = imm26_s[DATA_W-1:0];
      br_uncond = 1'b1;
      br_off    = $signed(off26[ADDR_W-1:0]);
      halt_req  = (instruction[25:0] == 26'd0);
    end else if (instruction[31:24] == OP_CBZ) begin
      imm       = imm19_s[DATA_W-1:0];
      alu_cntrl = ALU_PASS_B;
      br_cbz    = 1'b1;
      br_off    = $signed(off19[ADDR_W-1:0]);
    end else if (instruction[31:24] == OP_BCOND && instruction[4:0] == COND_LT) begin
      imm    = imm19_s[DATA_W-1:0];
      br_lt  = 1'b1;
      br_off = $signed(off19[ADDR_W-1:0]);
    end else begin
      illegal = 1'b1;
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Single-cycle control sequencer: holds PC, NZVC flags and the RUN/HALT
// state; all control outputs are combinational from instruction and state.
//   clk   : clock, all state on rising edge
//   reset : synchronous active-high, loads RESET_PC, clears flags, RUN
//   bus   : control_sequencer_if master (instruction/ALU flags in,
//           PC, fields, immediate, controls, flags, halted, illegal out)
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 reset,
  control_sequencer_if.master bus
);

  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [3:0]               flags_q, flags_d;
  state_t                   state_q, state_d;

  logic [4:0]               dec_rd, dec_rn, dec_rm;
  logic [DATA_W-1:0]        dec_imm;
  logic                     dec_reg2loc, dec_reg_write, dec_mem_write;
  logic                     dec_mem_to_reg, dec_alu_src;
  logic [2:0]               dec_alu_cntrl;
  logic [3:0]               dec_xfer_size;
  logic                     dec_flag_we, dec_br_uncond, dec_br_cbz, dec_br_lt;
  logic                     dec_halt_req, dec_illegal;
  logic signed [ADDR_W-1:0] dec_br_off;

  instr_decode #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_decode (
    .instruction (bus.instruction),
    .rd          (dec_rd),
    .rn          (dec_rn),
    .rm          (dec_rm),
    .imm         (dec_imm),
    .reg2loc     (dec_reg2loc),
    .reg_write   (dec_reg_write),
    .mem_write   (dec_mem_write),
    .mem_to_reg  (dec_mem_to_reg),
    .alu_src     (dec_alu_src),
    .alu_cntrl   (dec_alu_cntrl),
    .xfer_size   (dec_xfer_size),
    .flag_we     (dec_flag_we),
    .br_uncond   (dec_br_uncond),
    .br_cbz      (dec_br_cbz),
    .br_lt       (dec_br_lt),
    .halt_req    (dec_halt_req),
    .illegal     (dec_illegal),
    .br_off      (dec_br_off)
  );

  assign bus.PC        = pc_q;
  assign bus.flags     = flags_q;
  assign bus.Rd        = dec_rd;
  assign bus.Rn        = dec_rn;
  assign bus.Rm        = dec_rm;
  assign bus.imm       = dec_imm;
  assign bus.Reg2Loc   = dec_reg2loc;
  assign bus.MemToReg  = dec_mem_to_reg;
  assign bus.ALUSrc    = dec_alu_src;
  assign bus.alu_cntrl = dec_alu_cntrl;
  assign bus.xfer_size = dec_xfer_size;
  assign bus.illegal   = dec_illegal;
  assign bus.halted    = (state_q == ST_HALT);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q + ADDR_W'(4);
    flags_d      = flags_q;
    bus.RegWrite = dec_reg_write;
    bus.MemWrite = dec_mem_write;
    case (state_q)
      ST_RUN: begin
        // CBZ uses the live ALU zero; B.LT only ever sees registered flags.
        if (dec_br_uncond ||
            (dec_br_cbz && bus.alu_zero) ||
            (dec_br_lt && lt_taken(flags_q))) begin
          pc_d = pc_q + ADDR_W'(dec_br_off);
        end
        if (dec_flag_we) begin
          flags_d = {bus.alu_negative, bus.alu_zero, bus.alu_overflow, bus.alu_carry};
        end
        if (dec_halt_req) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: begin
        pc_d         = pc_q;
        bus.RegWrite = 1'b0;
        bus.MemWrite = 1'b0;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      flags_q <= '0;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      flags_q <= flags_d;
      state_q <= state_d;
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  localparam logic [31:0] NOP = 32'h0000_0000;

  localparam int K_ADDI = 0;
  localparam int K_ADDS = 1;
  localparam int K_SUBS = 2;
  localparam int K_LDUR = 3;
  localparam int K_STUR = 4;
  localparam int K_B    = 5;
  localparam int K_CBZ  = 6;
  localparam int K_BLT  = 7;
  localparam int K_ILL  = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  control_sequencer_if #(.ADDR_W(64), .DATA_W(64)) bus64();
  control_sequencer_if #(.ADDR_W(8),  .DATA_W(64)) bus8();

  control_sequencer #(.ADDR_W(64), .DATA_W(64), .RESET_PC(64'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus64)
  );

  control_sequencer #(.ADDR_W(8), .DATA_W(64), .RESET_PC(8'h0)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic n, input logic z,
                       input logic v, input logic c);
    bus64.instruction  = ins;
    bus64.alu_negative = n;
    bus64.alu_zero     = z;
    bus64.alu_overflow = v;
    bus64.alu_carry    = c;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  // Reference classification straight from the opcode table.
  function automatic int classify(input logic [31:0] i);
    if (i[31:22] == 10'b1001000100)                       return K_ADDI;
    if (i[31:21] == 11'b10101011000)                      return K_ADDS;
    if (i[31:21] == 11'b11101011000)                      return K_SUBS;
    if (i[31:21] == 11'b11111000010)                      return K_LDUR;
    if (i[31:21] == 11'b11111000000)                      return K_STUR;
    if (i[31:26] == 6'b000101)                            return K_B;
    if (i[31:24] == 8'b10110100)                          return K_CBZ;
    if (i[31:24] == 8'b01010100 && i[4:0] == 5'b01011)    return K_BLT;
    return K_ILL;
  endfunction

  task automatic test_reset();
    // branch and flag update presented during reset must be ignored
    reset = 1'b1;
    drive(32'h1400_0002, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    drive(32'hEB03_0041, 1'b1, 1'b1, 1'b1, 1'b1);
    cycle();
    reset = 1'b0;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus64.PC !== 64'h0) begin errors++; $display("FAIL reset_pc got %h want %h", bus64.PC, 64'h0); end
    checks++; if (bus64.flags !== 4'b0000) begin errors++; $display("FAIL reset_flags got %b want 0000", bus64.flags); end
    checks++; if (bus64.halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", bus64.halted); end
    checks++; if (bus64.illegal !== 1'b1) begin errors++; $display("FAIL nop_illegal got %b want 1", bus64.illegal); end
    checks++; if (bus64.RegWrite !== 1'b0 || bus64.MemWrite !== 1'b0) begin errors++; $display("FAIL nop_we got %b%b want 00", bus64.RegWrite, bus64.MemWrite); end
    cycle();
    checks++; if (bus64.PC !== 64'h4) begin errors++; $display("FAIL nop_pc4 got %h want 4", bus64.PC); end
    cycle();
    checks++; if (bus64.PC !== 64'h8) begin errors++; $display("FAIL nop_pc8 got %h want 8", bus64.PC); end
  endtask

  task automatic test_addi();
    do_reset();
    drive(32'h9100_17E1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus64.Rd !== 5'd1) begin errors++; $display("FAIL addi_rd got %0d want 1", bus64.Rd); end
    checks++; if (bus64.Rn !== 5'd31) begin errors++; $display("FAIL addi_rn got %0d want 31", bus64.Rn); end
    checks++; if (bus64.imm !== 64'd5) begin errors++; $display("FAIL addi_imm got %0d want 5", bus64.imm); end
    checks++; if (bus64.ALUSrc !== 1'b1) begin errors++; $display("FAIL addi_alusrc got %b want 1", bus64.ALUSrc); end
    checks++; if (bus64.alu_cntrl !== 3'b010) begin errors++; $display("FAIL addi_alu got %b want 010", bus64.alu_cntrl); end
    checks++; if (bus64.RegWrite !== 1'b1) begin errors++; $display("FAIL addi_regwrite got %b want 1", bus64.RegWrite); end
    checks++; if (bus64.MemWrite !== 1'b0) begin errors++; $display("FAIL addi_memwrite got %b want 0", bus64.MemWrite); end
    cycle();
    checks++; if (bus64.PC !== 64'h4) begin errors++; $display("FAIL addi_pc got %h want 4", bus64.PC); end
  endtask

  task automatic test_subs_blt();
    for (int rep = 0; rep < 2; rep++) begin
      logic       vv;
      logic [3:0] exp_f;
      logic [63:0] exp_pc;
      vv     = (rep == 1);
      exp_f  = {1'b1, 1'b0, vv, 1'b0};
      exp_pc = vv ? 64'h14 : 64'h1C;
      do_reset();
      cycle(); cycle(); cycle();
      drive(32'hEB03_0041, 1'b1, 1'b0, vv, 1'b0);
      cycle();
      checks++; if (bus64.PC !== 64'h10) begin errors++; $display("FAIL subs_pc rep%0d got %h want 10", rep, bus64.PC); end
      checks++; if (bus64.flags !== exp_f) begin errors++; $display("FAIL subs_flags rep%0d got %b want %b", rep, bus64.flags, exp_f); end
      // live ALU inputs chosen to suggest the opposite outcome
      drive(32'h5400_006B, vv, 1'b0, 1'b0, 1'b0);
      cycle();
      checks++; if (bus64.PC !== exp_pc) begin errors++; $display("FAIL blt_pc rep%0d got %h want %h", rep, bus64.PC, exp_pc); end
      checks++; if (bus64.flags !== exp_f) begin errors++; $display("FAIL blt_flags_hold rep%0d got %b want %b", rep, bus64.flags, exp_f); end
    end
  endtask

  task automatic test_cbz();
    for (int rep = 0; rep < 2; rep++) begin
      logic        zz;
      logic [63:0] exp_pc;
      zz     = (rep == 0);
      exp_pc = zz ? 64'h18 : 64'h24;
      do_reset();
      for (int k = 0; k < 8; k++) cycle();
      checks++; if (bus64.PC !== 64'h20) begin errors++; $display("FAIL cbz_start rep%0d got %h want 20", rep, bus64.PC); end
      drive(32'hB4FF_FFC3, 1'b0, zz, 1'b0, 1'b0);
      #1;
      checks++; if (bus64.alu_cntrl !== 3'b000 || bus64.Reg2Loc !== 1'b0) begin errors++; $display("FAIL cbz_ctrl rep%0d got alu=%b r2l=%b want 000/0", rep, bus64.alu_cntrl, bus64.Reg2Loc); end
      cycle();
      checks++; if (bus64.PC !== exp_pc) begin errors++; $display("FAIL cbz_pc rep%0d got %h want %h", rep, bus64.PC, exp_pc); end
    end
  endtask

  task automatic test_halt();
    logic [31:0] pool [4];
    pool[0] = 32'h9100_17E1;
    pool[1] = 32'hF800_0062;
    pool[2] = 32'hEB03_0041;
    pool[3] = 32'h1400_0010;
    do_reset();
    cycle();
    drive(32'h1400_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    checks++; if (bus64.halted !== 1'b0) begin errors++; $display("FAIL halt_pre got %b want 0", bus64.halted); end
    cycle();
    checks++; if (bus64.halted !== 1'b1) begin errors++; $display("FAIL halt_enter got %b want 1", bus64.halted); end
    checks++; if (bus64.PC !== 64'h4) begin errors++; $display("FAIL halt_pc0 got %h want 4", bus64.PC); end
    for (int k = 0; k < 10; k++) begin
      drive(pool[$urandom_range(0, 3)], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      #1;
      checks++; if (bus64.RegWrite !== 1'b0 || bus64.MemWrite !== 1'b0) begin errors++; $display("FAIL halt_we k%0d got %b%b want 00", k, bus64.RegWrite, bus64.MemWrite); end
      cycle();
      checks++; if (bus64.PC !== 64'h4 || bus64.halted !== 1'b1) begin errors++; $display("FAIL halt_hold k%0d got pc=%h h=%b want 4/1", k, bus64.PC, bus64.halted); end
      checks++; if (bus64.flags !== 4'b0000) begin errors++; $display("FAIL halt_flags k%0d got %b want 0000", k, bus64.flags); end
    end
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    reset = 1'b0;
    checks++; if (bus64.PC !== 64'h0 || bus64.halted !== 1'b0) begin errors++; $display("FAIL halt_reset got pc=%h h=%b want 0/0", bus64.PC, bus64.halted); end
    cycle();
    checks++; if (bus64.PC !== 64'h4) begin errors++; $display("FAIL halt_resume got %h want 4", bus64.PC); end
  endtask

  task automatic test_wrap();
    reset = 1'b1;
    bus8.instruction = NOP;
    cycle();
    cycle();
    reset = 1'b0;
    for (int k = 0; k < 63; k++) cycle();
    checks++; if (bus8.PC !== 8'hFC) begin errors++; $display("FAIL wrap_start got %h want fc", bus8.PC); end
    bus8.instruction = 32'h9100_17E1;
    #1;
    checks++; if (bus8.illegal !== 1'b0) begin errors++; $display("FAIL wrap_legal got %b want 0", bus8.illegal); end
    cycle();
    checks++; if (bus8.PC !== 8'h00) begin errors++; $display("FAIL wrap_pc got %h want 00", bus8.PC); end
    bus8.instruction = 32'hFFFF_FFFF;
    #1;
    checks++; if (bus8.illegal !== 1'b1 || bus8.RegWrite !== 1'b0 || bus8.MemWrite !== 1'b0) begin errors++; $display("FAIL wrap_illegal got ill=%b we=%b%b want 1/00", bus8.illegal, bus8.RegWrite, bus8.MemWrite); end
    cycle();
    checks++; if (bus8.PC !== 8'h04) begin errors++; $display("FAIL wrap_illegal_pc got %h want 04", bus8.PC); end
    bus8.instruction = NOP;
  endtask

  task automatic test_random();
    logic [63:0] pc_m;
    logic [3:0]  flags_m;
    do_reset();
    pc_m    = 64'h0;
    flags_m = 4'h0;
    for (int it = 0; it < 300; it++) begin
      logic [31:0] ins;
      logic        n, z, v, c;
      int          kind;
      longint      off;
      logic [63:0] nxt;
      logic        exp_rw, exp_mw;
      logic [25:0] r26;
      case ($urandom_range(0, 8))
        0: ins = 32'h9100_0000 | ($urandom & 32'h003F_FFFF);
        1: ins = 32'hAB00_0000 | ($urandom & 32'h001F_FFFF);
        2: ins = 32'hEB00_0000 | ($urandom & 32'h001F_FFFF);
        3: ins = 32'hF840_0000 | ($urandom & 32'h001F_FFFF);
        4: ins = 32'hF800_0000 | ($urandom & 32'h001F_FFFF);
        5: begin
          r26 = 26'($urandom_range(1, 32'h03FF_FFFF));
          ins = {6'b000101, r26};
        end
        6: ins = 32'hB400_0000 | ($urandom & 32'h00FF_FFFF);
        7: ins = 32'h5400_000B | ($urandom & 32'h00FF_FFE0);
        default: ins = $urandom;
      endcase
      if (ins[31:26] == 6'b000101 && ins[25:0] == 26'd0) ins = NOP;
      n = 1'($urandom_range(0, 1));
      z = 1'($urandom_range(0, 1));
      v = 1'($urandom_range(0, 1));
      c = 1'($urandom_range(0, 1));
      drive(ins, n, z, v, c);
      #1;
      kind   = classify(ins);
      exp_rw = (kind == K_ADDI || kind == K_ADDS || kind == K_SUBS || kind == K_LDUR);
      exp_mw = (kind == K_STUR);
      checks++; if (bus64.RegWrite !== exp_rw || bus64.MemWrite !== exp_mw) begin errors++; $display("FAIL rnd_we it%0d ins=%h got %b%b want %b%b", it, ins, bus64.RegWrite, bus64.MemWrite, exp_rw, exp_mw); end
      checks++; if (bus64.illegal !== (kind == K_ILL)) begin errors++; $display("FAIL rnd_illegal it%0d ins=%h got %b want %b", it, ins, bus64.illegal, kind == K_ILL); end
      checks++; if (bus64.Rd !== ins[4:0] || bus64.Rn !== ins[9:5] || bus64.Rm !== ins[20:16]) begin errors++; $display("FAIL rnd_fields it%0d ins=%h got %0d/%0d/%0d", it, ins, bus64.Rd, bus64.Rn, bus64.Rm); end
      if (kind == K_ADDI) begin
        checks++; if (bus64.imm !== 64'(ins[21:10]) || bus64.alu_cntrl !== 3'b010) begin errors++; $display("FAIL rnd_addi it%0d got imm=%h alu=%b want %h/010", it, bus64.imm, bus64.alu_cntrl, 64'(ins[21:10])); end
      end
      if (kind == K_LDUR) begin
        off = $signed(ins[20:12]);
        checks++; if (bus64.imm !== 64'(off) || bus64.MemToReg !== 1'b1 || bus64.xfer_size !== 4'd8) begin errors++; $display("FAIL rnd_ldur it%0d got imm=%h m2r=%b sz=%0d want %h/1/8", it, bus64.imm, bus64.MemToReg, bus64.xfer_size, 64'(off)); end
      end
      if (kind == K_SUBS) begin
        checks++; if (bus64.alu_cntrl !== 3'b011 || bus64.Reg2Loc !== 1'b1) begin errors++; $display("FAIL rnd_subs it%0d got alu=%b r2l=%b want 011/1", it, bus64.alu_cntrl, bus64.Reg2Loc); end
      end
      // reference next-state
      nxt = pc_m + 64'd4;
      case (kind)
        K_B: begin
          off = $signed(ins[25:0]);
          nxt = pc_m + 64'(off * 4);
        end
        K_CBZ: if (z) begin
          off = $signed(ins[23:5]);
          nxt = pc_m + 64'(off * 4);
        end
        K_BLT: if (flags_m[3] != flags_m[1]) begin
          off = $signed(ins[23:5]);
          nxt = pc_m + 64'(off * 4);
        end
        K_ADDS, K_SUBS: flags_m = {n, z, v, c};
        default: ;
      endcase
      pc_m = nxt;
      cycle();
      checks++; if (bus64.PC !== pc_m) begin errors++; $display("FAIL rnd_pc it%0d ins=%h got %h want %h", it, ins, bus64.PC, pc_m); end
      checks++; if (bus64.flags !== flags_m || bus64.halted !== 1'b0) begin errors++; $display("FAIL rnd_flags it%0d got %b h=%b want %b h=0", it, bus64.flags, bus64.halted, flags_m); end
    end
  endtask

  initial begin
    reset = 1'b1;
    drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0);
    bus8.instruction  = NOP;
    bus8.alu_zero     = 1'b0;
    bus8.alu_negative = 1'b0;
    bus8.alu_overflow = 1'b0;
    bus8.alu_carry    = 1'b0;
    test_reset();
    test_addi();
    test_subs_blt();
    test_cbz();
    test_halt();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, meaning PC width in bits.
REQ-002 SHALL have parameter DATA_W, default 64, meaning datapath and immediate width.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning PC value loaded on reset.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-006 SHALL have port instruction, input, 32 bits, the current instruction from instruction memory.
REQ-007 SHALL have ports alu_zero, alu_negative, alu_overflow and alu_carry, each an input of 1 bit, the same-cycle ALU flags.
REQ-008 SHALL have port PC, output, ADDR_W bits, the registered program counter.
REQ-009 SHALL have ports Rd, Rn and Rm, each an output of 5 bits, the register specifiers.
REQ-010 SHALL have port imm, output, DATA_W bits, the extended immediate.
REQ-011 SHALL have ports Reg2Loc, RegWrite, MemWrite, MemToReg and ALUSrc, each an output of 1 bit, the datapath controls.
REQ-012 SHALL have port alu_cntrl, output, 3 bits, with codes PASS_B=000, ADD=010, SUB=011, AND=100, OR=101, XOR=110.
REQ-013 SHALL have port xfer_size, output, 4 bits, the memory transfer size in bytes.
REQ-014 SHALL have port flags, output, 4 bits, the registered {N,Z,V,C}.
REQ-015 SHALL have port halted, output, 1 bit, high in the HALT state.
REQ-016 SHALL have port illegal, output, 1 bit, high while the current opcode is unrecognised.

Function
REQ-017 SHALL decode opcodes as follows:
- ADDI: bits[31:22]=1001000100; imm = zero-extended [21:10]; ALUSrc=1; ADD; RegWrite=1.
- ADDS: bits[31:21]=10101011000; Reg2Loc=1; ADD; RegWrite=1; flags update.
- SUBS: bits[31:21]=11101011000; Reg2Loc=1; SUB; RegWrite=1; flags update.
- LDUR: bits[31:21]=11111000010; imm = sign-extended [20:12]; ALUSrc=1; ADD; MemToReg=1; RegWrite=1; xfer_size=8.
- STUR: bits[31:21]=11111000000; Reg2Loc=0; ALUSrc=1; ADD; MemWrite=1; xfer_size=8.
- B: bits[31:26]=000101; imm26.
- CBZ: bits[31:24]=10110100; Reg2Loc=0; PASS_B; imm19 = [23:5].
- B.LT: bits[31:24]=01010100 with [4:0]=01011; imm19.
REQ-018 SHALL drive field outputs as Rd=[4:0], Rn=[9:5], Rm=[20:16]; when Reg2Loc=0 the second read register is Rd (Rt).
REQ-019 SHALL treat an unrecognised opcode as a NOP: all write enables 0, illegal=1, next PC = PC+4.
REQ-020 SHALL compute next PC as PC+4 by default; a taken branch SHALL give PC + (sign-extended offset << 2); all PC arithmetic is modulo 2^ADDR_W.
REQ-021 SHALL take CBZ when alu_zero=1 in the same cycle.
REQ-022 SHALL take B.LT when the registered flags satisfy N != V, i.e. flags produced by an earlier instruction, never the same cycle.
REQ-023 SHALL load flags from the alu_* inputs on ADDS/SUBS only; all other instructions hold flags.
REQ-024 SHALL implement a two-state FSM {RUN, HALT}: RUN goes to HALT when B with imm26=0 executes; HALT exits only on reset.
REQ-025 SHALL, in HALT, hold PC and flags, force RegWrite=MemWrite=0, and set halted=1.
REQ-026 SHALL keep all control outputs combinational from instruction and state; PC, flags and state are the only registers.

Reset
REQ-027 SHALL, on reset=1 at a clock edge, set PC=RESET_PC, flags=0000 and state=RUN, overriding any branch, flag update or halt in that cycle, including reset mid-operation or while halted.

Structure
REQ-028 SHALL place the opcode patterns, ALU codes, the B.LT condition code and the state enum in a shared package, cpu_pkg.
REQ-029 SHALL implement decoding in one combinational sub-module, instr_decode; control_sequencer holds the PC, flags and FSM.

Verification
REQ-030 Reset scenario: assert reset 2 cycles, then NOP stream -> PC=0 after reset, then PC 4, 8; flags=0; halted=0.
REQ-031 ADDI scenario: instruction 0x910017E1 -> Rd=1, Rn=31, imm=5, ALUSrc=1, alu_cntrl=010, RegWrite=1, MemWrite=0.
REQ-032 SUBS/B.LT scenario: SUBS with alu_negative=1, alu_overflow=0, then B.LT imm19=+3 at PC=0x10 -> flags N=1, V=0; next PC=0x1C. Repeat with N=V=1 -> next PC=0x14.
REQ-033 CBZ scenario: CBZ imm19=-2 at PC=0x20 -> alu_zero=1 gives next PC=0x18; alu_zero=0 gives next PC=0x24.
REQ-034 Halt scenario: B imm26=0 -> halted=1 next cycle; PC unchanged for 10 cycles; RegWrite=MemWrite=0; reset returns PC=RESET_PC, halted=0.
REQ-035 Wrap scenario: with ADDR_W=8, a non-branch at PC=0xFC -> next PC=0x00; an unknown opcode -> illegal=1 and PC+4.
